dtree_walker: RTL and testbench

DTREE_WALKER -- requirements
Module: dtree_walker

---
 rtl/dtree_pkg.sv | 54 +++++
 rtl/dtree_node_eval.sv | 55 +++++
 rtl/dtree_walker.sv | 103 ++++++++++
 tb/tb_dtree_walker.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dtree_pkg.sv
// Shared definitions for the decision-tree walker.
//   fidx_w()      : width of the feature-index field for a given feature count
//   off_*()       : bit offsets of each field inside a node word (class at LSB)
//   node_w()      : total node-word width
//   state_e       : walker FSM states
//   node_t        : node word laid out as a struct for the default geometry
package dtree_pkg;

  function automatic int fidx_w(input int n_feat);
    return (n_feat > 1) ? $clog2(n_feat) : 1;
  endfunction

  // Node word, MSB first: internal | feat_idx | thr | left | right | class
  function automatic int off_right(input int cw);
    return cw;
  endfunction
  function automatic int off_left(input int aw, input int cw);
    return cw + aw;
  endfunction
  function automatic int off_thr(input int aw, input int cw);
    return cw + 2 * aw;
  endfunction
  function automatic int off_fidx(input int fw, input int aw, input int cw);
    return cw + 2 * aw + fw;
  endfunction
  function automatic int off_int(input int nf, input int fw, input int aw, input int cw);
    return off_fidx(fw, aw, cw) + fidx_w(nf);
  endfunction
  function automatic int node_w(input int nf, input int fw, input int aw, input int cw);
    return off_int(nf, fw, aw, cw) + 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int D_N_FEAT  = 18;
  localparam int D_FEAT_W  = 8;
  localparam int D_NODE_AW = 7;
  localparam int D_CLASS_W = 2;
  localparam int D_FIDX_W  = fidx_w(D_N_FEAT);

  typedef struct packed {
    logic                 internal;
    logic [D_FIDX_W-1:0]  feat_idx;
    logic [D_FEAT_W-1:0]  thr;
    logic [D_NODE_AW-1:0] left;
    logic [D_NODE_AW-1:0] right;
    logic [D_CLASS_W-1:0] cls;
  } node_t;

endpackage

// File: rtl/dtree_node_eval.sv
// Combinational evaluation of one tree node.
//   node      : node word at the current address
//   feat      : registered feature vector, feature i at [i*FEAT_W +: FEAT_W]
//   depth     : internal nodes already traversed in this inference
//   next_addr : child chosen by feat[feat_idx] <= thr ? left : right
//   is_leaf   : node is a leaf, cls carries its label
//   is_err    : bad feature index, or the depth budget runs out on this node
module dtree_node_eval import dtree_pkg::*; #(
  parameter int N_FEAT    = 18,
  parameter int FEAT_W    = 8,
  parameter int NODE_AW   = 7,
  parameter int CLASS_W   = 2,
  parameter int MAX_DEPTH = 16,
  localparam int NODE_W   = node_w(N_FEAT, FEAT_W, NODE_AW, CLASS_W),
  localparam int DEPTH_W  = $clog2(MAX_DEPTH + 1)
) (
  input  logic [NODE_W-1:0]        node,
  input  logic [N_FEAT*FEAT_W-1:0] feat,
  input  logic [DEPTH_W-1:0]       depth,
  output logic [NODE_AW-1:0]       next_addr,
  output logic                     is_leaf,
  output logic                     is_err,
  output logic [CLASS_W-1:0]       cls
);
  localparam int FIDX_W = fidx_w(N_FEAT);
  localparam int O_R    = off_right(CLASS_W);
  localparam int O_L    = off_left(NODE_AW, CLASS_W);
  localparam int O_T    = off_thr(NODE_AW, CLASS_W);
  localparam int O_F    = off_fidx(FEAT_W, NODE_AW, CLASS_W);
  localparam int O_I    = off_int(N_FEAT, FEAT_W, NODE_AW, CLASS_W);

  logic              internal;
  logic [FIDX_W-1:0] fidx;
  logic [FEAT_W-1:0] thr, sel;

  assign internal = node[O_I];
  assign fidx     = node[O_F +: FIDX_W];
  assign thr      = node[O_T +: FEAT_W];
  assign cls      = node[0 +: CLASS_W];

  // Loop-based mux so an out-of-range index selects zero instead of
  // indexing past the vector; that case is flagged as an error below.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_FEAT; i++)
      if (int'(fidx) == i) sel = feat[i*FEAT_W +: FEAT_W];
  end

  assign next_addr = (sel <= thr) ? node[O_L +: NODE_AW] : node[O_R +: NODE_AW];
  assign is_leaf   = !internal;
  // The node being evaluated now is visit depth+1; an internal node on the
  // last allowed visit means no leaf will be found within budget.
  assign is_err    = internal && ((int'(fidx) >= N_FEAT) ||
                                  (depth == DEPTH_W'(MAX_DEPTH - 1)));
endmodule

// File: rtl/dtree_walker.sv
// Decision-tree inference engine: walks a register-resident binary tree,
// one node per cycle, from node 0 to a leaf.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : feature-vector input handshake (ready only in IDLE)
//   in_feat             : N_FEAT unsigned features, feature i at [i*FEAT_W +: FEAT_W]
//   out_valid/out_ready : result handshake (valid only in DONE)
//   out_class, out_err  : leaf label, or 0 with err on bad index / depth overrun
//   cfg_we/addr/data    : node-word write port, honoured only in IDLE
//   cfg_busy            : an inference is in flight, cfg writes are dropped
module dtree_walker import dtree_pkg::*; #(
  parameter int N_FEAT    = 18,
  parameter int FEAT_W    = 8,
  parameter int NODE_AW   = 7,
  parameter int CLASS_W   = 2,
  parameter int MAX_DEPTH = 16,
  localparam int NODE_W   = node_w(N_FEAT, FEAT_W, NODE_AW, CLASS_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err,
  input  logic                     cfg_we,
  input  logic [NODE_AW-1:0]       cfg_addr,
  input  logic [NODE_W-1:0]        cfg_data,
  output logic                     cfg_busy
);
  localparam int NODES   = 2 ** NODE_AW;
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] WALK = ST_WALK;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0]               state;
  logic [NODE_W-1:0]        mem [NODES];
  logic [N_FEAT*FEAT_W-1:0] feat_r;
  logic [NODE_AW-1:0]       cur_addr, next_addr;
  logic [DEPTH_W-1:0]       depth;
  logic                     is_leaf, is_err;
  logic [CLASS_W-1:0]       cls;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign cfg_busy  = (state != IDLE);

  dtree_node_eval #(
    .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .NODE_AW(NODE_AW),
    .CLASS_W(CLASS_W), .MAX_DEPTH(MAX_DEPTH)
  ) u_eval (
    .node(mem[cur_addr]), .feat(feat_r), .depth(depth),
    .next_addr(next_addr), .is_leaf(is_leaf), .is_err(is_err), .cls(cls)
  );

  // All-zero node word is a leaf with class 0, so reset yields a valid tree.
  // A write and an accept in the same IDLE cycle both land on this edge, and
  // the first node read happens in WALK, so the new node is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NODES; i++) mem[i] <= '0;
    end else if (cfg_we && state == IDLE) begin
      mem[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      feat_r    <= '0;
      cur_addr  <= '0;
      depth     <= '0;
      out_class <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          feat_r   <= in_feat;
          cur_addr <= '0;
          depth    <= '0;
          state    <= WALK;
        end
        WALK: if (is_leaf) begin
          out_class <= cls;
          out_err   <= 1'b0;
          state     <= DONE;
        end else if (is_err) begin
          out_class <= '0;
          out_err   <= 1'b1;
          state     <= DONE;
        end else begin
          cur_addr <= next_addr;
          depth    <= depth + DEPTH_W'(1);
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dtree_walker.sv
module tb_dtree_walker;
  import dtree_pkg::*;

  localparam int NF = 18, FW = 8, AW = 7, CW = 2, MD = 16;
  localparam int FV = NF * FW;

  logic          clk = 1'b0, rst = 1'b1;
  logic          in_valid = 1'b0, in_ready;
  logic [FV-1:0] in_feat = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [CW-1:0] out_class;
  logic          out_err;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  node_t         cfg_data = '0;
  logic          cfg_busy;

  int checks = 0, failures = 0;
  node_t mdl [2**AW];

  dtree_walker #(.N_FEAT(NF), .FEAT_W(FW), .NODE_AW(AW), .CLASS_W(CW), .MAX_DEPTH(MD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_err(out_err),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_busy(cfg_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic node_t mkleaf(input int c);
    node_t n = '0;
    n.cls = CW'(c);
    return n;
  endfunction

  function automatic node_t mkint(input int fi, input int thr, input int l, input int r);
    node_t n = '0;
    n.internal = 1'b1;
    n.feat_idx = D_FIDX_W'(fi);
    n.thr      = FW'(thr);
    n.left     = AW'(l);
    n.right    = AW'(r);
    return n;
  endfunction

  function automatic logic [FV-1:0] f7(input int x);
    logic [FV-1:0] f = '0;
    f[7*FW +: FW] = FW'(x);
    return f;
  endfunction

  // Reference walk: follow the tree from node 0, counting visited nodes.
  function automatic void model(input logic [FV-1:0] f, output int c, output int e, output int l);
    int    a;
    node_t n;
    a = 0; c = 0; e = 1; l = MD;
    for (int d = 1; d <= MD; d++) begin
      n = mdl[a];
      if (!n.internal) begin c = int'(n.cls); e = 0; l = d; return; end
      if (int'(n.feat_idx) >= NF || d == MD) begin c = 0; e = 1; l = d; return; end
      a = (int'(f[int'(n.feat_idx)*FW +: FW]) <= int'(n.thr)) ? int'(n.left) : int'(n.right);
    end
  endfunction

  task automatic write_node(input int a, input node_t n);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = n;
    @(negedge clk);
    cfg_we = 1'b0;
    mdl[a] = n;
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic start_inf(input logic [FV-1:0] f, output int lat);
    @(negedge clk);
    in_feat = f; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
  endtask

  task automatic finish_inf(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_ovalid_drop"}, 32'(out_valid), 0);
    chk({nm, "_ready_back"}, 32'(in_ready), 1);
  endtask

  task automatic run_inf(input logic [FV-1:0] f, input int ec, input int ee, input int el, input string nm);
    int lat;
    start_inf(f, lat);
    chk({nm, "_lat"}, 32'(lat), 32'(el));
    chk({nm, "_class"}, 32'(out_class), 32'(ec));
    chk({nm, "_err"}, 32'(out_err), 32'(ee));
    finish_inf(nm);
  endtask

  typedef struct {
    int x7;
    int cls;
    int lat;
  } vec_t;
  vec_t tbl [5];

  initial begin
    int lat, c, e, l;
    logic [FV-1:0] f;

    tbl[0] = '{162, 1, 2};
    tbl[1] = '{163, 3, 2};
    tbl[2] = '{0,   1, 2};
    tbl[3] = '{255, 3, 2};
    tbl[4] = '{161, 1, 2};
    for (int i = 0; i < 2**AW; i++) mdl[i] = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_cfg_busy", 32'(cfg_busy), 0);
    chk("rst_out_class", 32'(out_class), 0);
    chk("rst_out_err", 32'(out_err), 0);

    run_inf(32'hDEAD, 0, 0, 1, "rootleaf");

    write_node(0, mkint(7, 162, 1, 2));
    write_node(1, mkleaf(1));
    write_node(2, mkleaf(3));
    foreach (tbl[i]) run_inf(f7(tbl[i].x7), tbl[i].cls, 0, tbl[i].lat, "tbl");

    // Stall in DONE: outputs hold, cfg writes dropped.
    start_inf(f7(162), lat);
    chk("stall_lat", 32'(lat), 2);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 1; cfg_data = mkleaf(2);
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_class", 32'(out_class), 1);
      chk("stall_err", 32'(out_err), 0);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_busy", 32'(cfg_busy), 1);
    end
    cfg_we = 1'b0;
    finish_inf("stall");
    run_inf(f7(162), 1, 0, 2, "after_stall");

    // Write and accept in the same IDLE cycle.
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 0; cfg_data = mkleaf(2);
    in_feat = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    mdl[0] = mkleaf(2);
    wait_out(lat);
    chk("wfirst_lat", 32'(lat), 1);
    chk("wfirst_class", 32'(out_class), 2);
    finish_inf("wfirst");

    write_node(0, mkint(0, 0, 0, 0));
    run_inf(f7(9), 0, 1, 17 - 1, "selfloop");
    write_node(0, mkint(31, 0, 1, 2));
    run_inf(f7(9), 0, 1, 1, "badidx");

    // Random trees over nodes 0..7 (loops and bad indices allowed).
    for (int it = 0; it < 40; it++) begin
      for (int a = 0; a < 8; a++) begin
        if ($urandom_range(0, 2) == 0) write_node(a, mkleaf($urandom_range(0, 3)));
        else write_node(a, mkint($urandom_range(0, 19), $urandom_range(0, 15),
                                 $urandom_range(0, 7), $urandom_range(0, 7)));
      end
      for (int j = 0; j < 3; j++) begin
        for (int q = 0; q < NF; q++) f[q*FW +: FW] = FW'($urandom_range(0, 15));
        model(f, c, e, l);
        run_inf(f, c, e, l, "rand");
      end
    end

    // Reset during a 5-deep walk.
    for (int a = 0; a < 4; a++) write_node(a, mkint(0, 255, a + 1, a + 1));
    write_node(4, mkleaf(3));
    model('0, c, e, l);
    chk("chain_model_lat", 32'(l), 5);
    @(negedge clk);
    in_feat = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 2**AW; i++) mdl[i] = '0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_busy", 32'(cfg_busy), 0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", 32'(out_valid), 0);
    end
    run_inf('0, 0, 0, 1, "postrst_root");
    write_node(0, mkint(0, 255, 4, 4));
    run_inf('0, 0, 0, 2, "postrst_node4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
